// File: rtl/rapcore_spi_controller_if.sv
// Word stream and SPI pin bundle for the rapcore host-side SPI controller.
// The controller connects to the slave modport; the word source and peripheral use master.
interface rapcore_spi_controller_if #(
  parameter int unsigned WORD_W = 64
);
  logic [WORD_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_last;
  logic              tx_ready;
  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              SCK;
  logic              CS;
  logic              COPI;
  logic              CIPO;

  modport master (
    output tx_data, tx_valid, tx_last, CIPO,
    input  tx_ready, rx_data, rx_valid, busy, SCK, CS, COPI
  );

  modport slave (
    input  tx_data, tx_valid, tx_last, CIPO,
    output tx_ready, rx_data, rx_valid, busy, SCK, CS, COPI
  );
endinterface

// File: rtl/rapcore_spi_controller.sv
// Host-side SPI mode-0 controller: serialises 64-bit words MSB-first and captures the reply.
// Bursts keep CS low between words; every output is driven from a flop.
module rapcore_spi_controller #(
  parameter int unsigned WORD_W   = 64,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input  logic                     CLK,
  input  logic                     reset,
  rapcore_spi_controller_if.slave  bus
);
  localparam int unsigned PH_MAX = (CLK_DIV > CS_SETUP)
                                   ? ((CLK_DIV  > CS_HOLD) ? CLK_DIV  : CS_HOLD)
                                   : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int unsigned PH_W  = $clog2(PH_MAX + 1);
  localparam int unsigned BIT_W = $clog2(WORD_W + 1);

  localparam logic [PH_W-1:0]  DIV_LD   = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  SETUP_LD = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0]  HOLD_LD  = PH_W'(CS_HOLD - 1);
  localparam logic [BIT_W-1:0] BITS_LD  = BIT_W'(WORD_W);

  typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, WAIT_NEXT, HOLD} state_e;

  state_e             state_q, state_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WORD_W-1:0]  tx_sr_q, tx_sr_d;
  logic [WORD_W-1:0]  rx_sr_q, rx_sr_d;
  logic               last_q, last_d;
  logic               hold_hi_q, hold_hi_d;
  logic               word_done;

  logic               tx_ready_q, tx_ready_d;
  logic               busy_q, busy_d;
  logic               cs_q, cs_d;
  logic               sck_q, sck_d;
  logic               copi_q, copi_d;
  logic               rx_valid_q, rx_valid_d;
  logic [WORD_W-1:0]  rx_data_q, rx_data_d;

  logic accept;
  logic ph_done;

  assign accept  = bus.tx_valid && tx_ready_q;
  assign ph_done = (ph_q == '0);

  // State and datapath register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      bit_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      last_q     <= 1'b0;
      hold_hi_q  <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
      copi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      last_q     <= last_d;
      hold_hi_q  <= hold_hi_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      copi_q     <= copi_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // Next state; the phase counter reloads on every state entry
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    bit_d     = bit_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    last_d    = last_q;
    hold_hi_d = hold_hi_q;
    word_done = 1'b0;
    if (!ph_done) ph_d = ph_q - PH_W'(1);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          ph_d    = SETUP_LD;
          tx_sr_d = bus.tx_data;
          last_d  = bus.tx_last;
          bit_d   = BITS_LD;
        end
      end
      SETUP: begin
        if (ph_done) begin
          state_d = SCK_HI;
          ph_d    = DIV_LD;
        end
      end
      SCK_HI: begin
        // Falling SCK edge: capture CIPO and present the next COPI bit together
        if (ph_done) begin
          state_d = SCK_LO;
          ph_d    = DIV_LD;
          rx_sr_d = {rx_sr_q[WORD_W-2:0], bus.CIPO};
          tx_sr_d = {tx_sr_q[WORD_W-2:0], 1'b0};
          bit_d   = bit_q - BIT_W'(1);
        end
      end
      SCK_LO: begin
        if (ph_done) begin
          if (bit_q == '0) begin
            word_done = 1'b1;
            if (last_q) begin
              state_d   = HOLD;
              ph_d      = HOLD_LD;
              hold_hi_d = 1'b0;
            end else begin
              state_d = WAIT_NEXT;
            end
          end else begin
            state_d = SCK_HI;
            ph_d    = DIV_LD;
          end
        end
      end
      WAIT_NEXT: begin
        if (accept) begin
          state_d = SCK_HI;
          ph_d    = DIV_LD;
          tx_sr_d = bus.tx_data;
          last_d  = bus.tx_last;
          bit_d   = BITS_LD;
        end
      end
      HOLD: begin
        // Two equal halves: CS still low, then CS high as the minimum gap
        if (ph_done) begin
          if (hold_hi_q) begin
            state_d = IDLE;
          end else begin
            hold_hi_d = 1'b1;
            ph_d      = HOLD_LD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the next state
  always_comb begin
    tx_ready_d = (state_d == IDLE) || (state_d == WAIT_NEXT);
    busy_d     = (state_d != IDLE);
    sck_d      = (state_d == SCK_HI);
    cs_d       = !((state_d inside {SETUP, SCK_HI, SCK_LO, WAIT_NEXT}) ||
                   ((state_d == HOLD) && !hold_hi_d));
    copi_d     = tx_sr_d[WORD_W-1];
    rx_valid_d = word_done;
    rx_data_d  = word_done ? rx_sr_q : rx_data_q;
  end

  assign bus.tx_ready = tx_ready_q;
  assign bus.busy     = busy_q;
  assign bus.CS       = cs_q;
  assign bus.SCK      = sck_q;
  assign bus.COPI     = copi_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
endmodule
